// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit drain.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3,
    StParity = 3'd4
  } state_e;

  localparam int unsigned DefaultClksPerBit = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 32'd1 : unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts while enabled, flags the last and next-to-last cycle of a bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic last_cycle_o,
  output logic near_last_o
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastVal = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] NearVal = CntW'(CLKS_PER_BIT - 2);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign last_cycle_o = (cnt_q == LastVal);
  assign near_last_o  = (cnt_q == NearVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_cycle_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from a show-ahead FIFO and serialises them as 8N1 UART frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BitW = cnt_width(DATA_W);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  state_e            state_d, state_q;
  logic [DATA_W-1:0] shreg_d, shreg_q;
  logic [BitW-1:0]   bit_cnt_d, bit_cnt_q;
  logic              tx_d, tx_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              last_cycle, near_last, pop;
`ifdef UART_TX_PARITY_EN
  logic              par_d, par_q;
`endif

  // A new frame may start from idle or in the final stop-bit cycle (back-to-back).
  assign pop = tx_en & ~fifo_empty & ~rst &
               ((state_q == StIdle) | ((state_q == StStop) & last_cycle));

  assign fifo_rd_en = pop;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (state_q != StIdle),
    .clr_i       (pop),
    .last_cycle_o(last_cycle),
    .near_last_o (near_last)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    // Registered one cycle early so the pulse lands on the last stop-bit cycle.
    done_d    = (state_q == StStop) & near_last;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (pop) begin
      shreg_d = fifo_data;
      state_d = StStart;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_data;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StStart: begin
          if (last_cycle) begin
            state_d   = StData;
            tx_d      = shreg_q[0];
            bit_cnt_d = '0;
          end
        end
        StData: begin
          if (last_cycle) begin
            if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
              state_d = StParity;
              tx_d    = par_q;
`else
              state_d = StStop;
              tx_d    = 1'b1;
`endif
            end else begin
              shreg_d   = shreg_q >> 1;
              tx_d      = shreg_q[1];
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (last_cycle) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end
        end
`endif
        StStop: begin
          if (last_cycle) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule
